// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: walks the captured operand by up to STEP bits per
// cycle and publishes result/sout/err only when the operation completes.
module iterative_shifter #(
  parameter int REG_WIDTH = 32,
  parameter int STEP      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [REG_WIDTH-1:0]         op_a,
  input  logic [$clog2(REG_WIDTH)-1:0] nbits,
  input  logic [2:0]                   mode,
  output logic [REG_WIDTH-1:0]         result,
  output logic                         sout,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int CW = $clog2(REG_WIDTH);
  // remaining never exceeds REG_WIDTH-1, so capping the step there keeps k in CW bits
  localparam int              STEP_CAP = (STEP < REG_WIDTH) ? STEP : REG_WIDTH - 1;
  localparam logic [CW-1:0]   STEP_K   = CW'(STEP_CAP);
  localparam logic [CW:0]     WBITS    = (CW+1)'(REG_WIDTH);

  localparam logic [2:0] M_LSL = 3'b000, M_LSR = 3'b001, M_ASL = 3'b010,
                         M_ASR = 3'b011, M_ROL = 3'b100, M_ROR = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [2:0]           mode;
    logic [CW-1:0]        remaining;
    logic [REG_WIDTH-1:0] work;
  } job_t;

  state_t               state;
  job_t                 job;
  logic [CW-1:0]        k;
  logic [CW-1:0]        lidx;
  logic [CW-1:0]        ridx;
  logic [REG_WIDTH-1:0] step_val;
  logic                 step_out;
  logic                 legal;

  function automatic logic [REG_WIDTH-1:0] shift_by(input logic [REG_WIDTH-1:0] v,
                                                     input logic [CW-1:0] n,
                                                     input logic [2:0] m);
    logic [CW:0] back;
    back = WBITS - {1'b0, n};
    case (m)
      M_LSL, M_ASL: return v << n;
      M_LSR:        return v >> n;
      M_ASR:        return $unsigned($signed(v) >>> n);
      M_ROL:        return (v << n) | (v >> back);
      M_ROR:        return (v >> n) | (v << back);
      default:      return v;
    endcase
  endfunction

  assign legal = (mode <= M_ROR);

  always_comb begin
    k        = (job.remaining > STEP_K) ? STEP_K : job.remaining;
    lidx     = CW'(WBITS - {1'b0, k});
    ridx     = k - CW'(1);
    step_val = shift_by(job.work, k, job.mode);
    // even modes move left; the last bit leaving the word is the one reported
    step_out = job.mode[0] ? job.work[ridx] : job.work[lidx];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      job    <= '0;
      result <= '0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            job.work      <= op_a;
            job.mode      <= mode;
            job.remaining <= nbits;
            if (nbits == '0 || !legal) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= op_a;
              sout   <= 1'b0;
              err    <= !legal;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
          end
        end
        BUSY: begin
          job.work      <= step_val;
          job.remaining <= job.remaining - k;
          if (job.remaining == k) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= step_val;
            sout   <= step_out;
            err    <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
